// File: rtl/sc_level_advance_pulser.sv
// sc_level_advance_pulser: qualifies the frog sitting on the goal row for
// HOLD_CYCLES consecutive edges. It then emits one active-low level_up pulse
// and a one-cycle frog restart request. After that it stays locked out in
// COOLDOWN until the cooldown has elapsed and the frog has left the goal row.
module sc_level_advance_pulser #(
    parameter int ROW_DATAWIDTH   = 3,
    parameter int GOAL_ROW        = 7,
    parameter int HOLD_CYCLES     = 4,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int CNT_DATAWIDTH   = 8
) (
    input  logic                     SC_COUNTER_LEVELS_CLOCK_50,
    input  logic                     SC_COUNTER_LEVELS_RESET_InHigh,
    input  logic [ROW_DATAWIDTH-1:0] frog_row_InBus,
    input  logic                     game_enable_InHigh,
    input  logic                     collision_InLow,
    output logic                     level_up_OutLow,
    output logic                     frog_restart_OutHigh,
    output logic                     busy_OutHigh
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        QUALIFY  = 3'd1,
        PULSE    = 3'd2,
        RESTART  = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    localparam logic [ROW_DATAWIDTH-1:0] GOAL_ROW_V = ROW_DATAWIDTH'(GOAL_ROW);
    localparam logic [CNT_DATAWIDTH-1:0] HOLD_LAST  = CNT_DATAWIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_DATAWIDTH-1:0] CD_LAST    = CNT_DATAWIDTH'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_DATAWIDTH-1:0] CNT_ONE    = CNT_DATAWIDTH'(1);
    localparam logic [CNT_DATAWIDTH-1:0] CNT_ZERO   = '0;

    state_t                   state_q, state_d;
    logic [CNT_DATAWIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_DATAWIDTH-1:0] cd_cnt_q, cd_cnt_d;
    logic                     at_goal;
    logic                     qualify;

    assign at_goal = (frog_row_InBus == GOAL_ROW_V);
    assign qualify = game_enable_InHigh & collision_InLow & at_goal;

    // State and counter registers; reset takes effect immediately, even mid-pulse
    always_ff @(posedge SC_COUNTER_LEVELS_CLOCK_50 or posedge SC_COUNTER_LEVELS_RESET_InHigh) begin
        if (SC_COUNTER_LEVELS_RESET_InHigh) begin
            state_q    <= IDLE;
            hold_cnt_q <= CNT_ZERO;
            cd_cnt_q   <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cd_cnt_q   <= cd_cnt_d;
        end
    end

    // Next-state logic: qualify on goal row, pulse once, restart, then lock out
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cd_cnt_d   = cd_cnt_q;
        case (state_q)
            IDLE: begin
                hold_cnt_d = CNT_ZERO;
                if (qualify) begin
                    if (HOLD_CYCLES == 1) begin
                        state_d = PULSE;
                    end else begin
                        state_d    = QUALIFY;
                        hold_cnt_d = CNT_ONE;
                    end
                end
            end
            QUALIFY: begin
                if (!qualify) begin
                    state_d    = IDLE;
                    hold_cnt_d = CNT_ZERO;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = PULSE;
                    hold_cnt_d = CNT_ZERO;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            PULSE: begin
                state_d = RESTART;
            end
            RESTART: begin
                state_d  = COOLDOWN;
                cd_cnt_d = CNT_ZERO;
            end
            COOLDOWN: begin
                if ((cd_cnt_q == CD_LAST) && !at_goal) begin
                    state_d  = IDLE;
                    cd_cnt_d = CNT_ZERO;
                end else if (cd_cnt_q != CD_LAST) begin
                    cd_cnt_d = cd_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = CNT_ZERO;
                cd_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Moore outputs decoded purely from the state register
    always_comb begin
        level_up_OutLow      = 1'b1;
        frog_restart_OutHigh = 1'b0;
        busy_OutHigh         = 1'b1;
        case (state_q)
            IDLE:    busy_OutHigh         = 1'b0;
            PULSE:   level_up_OutLow      = 1'b0;
            RESTART: frog_restart_OutHigh = 1'b1;
            QUALIFY, COOLDOWN: busy_OutHigh = 1'b1;
            default: busy_OutHigh         = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sc_level_advance_pulser.sv
// tb_sc_level_advance_pulser: directed self-checking bench for the level
// advance pulser, with a small level counter fed by the active-low pulse.
module tb_sc_level_advance_pulser;

    logic       clock;
    logic       reset;
    logic [2:0] frogRow;
    logic       gameEnable;
    logic       collisionN;
    logic       levelUpN;
    logic       frogRestart;
    logic       busy;

    int checkCount = 0;
    int errorCount = 0;
    int levelCount = 0;

    sc_level_advance_pulser dut (
        .SC_COUNTER_LEVELS_CLOCK_50     (clock),
        .SC_COUNTER_LEVELS_RESET_InHigh (reset),
        .frog_row_InBus                 (frogRow),
        .game_enable_InHigh             (gameEnable),
        .collision_InLow                (collisionN),
        .level_up_OutLow                (levelUpN),
        .frog_restart_OutHigh           (frogRestart),
        .busy_OutHigh                   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Level counter attached to the pulse, as in the datapath
    always @(posedge clock) begin
        if (!levelUpN) levelCount <= levelCount + 1;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic colN, input logic [2:0] row);
        gameEnable = en;
        collisionN = colN;
        frogRow    = row;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int lows;
        int n;
        int startCount;
        logic prevLow;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 3'd0);

        // Reset with random inputs for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 3'($urandom));
            tick();
            checkOutput("rst_level", int'(levelUpN), 1);
            checkOutput("rst_restart", int'(frogRestart), 0);
            checkOutput("rst_busy", int'(busy), 0);
        end
        applyStimulus(1'b1, 1'b1, 3'd0);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_busy", int'(busy), 0);

        // Goal row held: pulse after 4th qualifying edge, restart next cycle
        startCount = levelCount;
        applyStimulus(1'b1, 1'b1, 3'd7);
        tick();
        checkOutput("q_e0_busy", int'(busy), 1);
        checkOutput("q_e0_level", int'(levelUpN), 1);
        tick();
        tick();
        checkOutput("q_e2_level", int'(levelUpN), 1);
        tick();
        checkOutput("q_e3_pulse", int'(levelUpN), 0);
        checkOutput("q_e3_restart", int'(frogRestart), 0);
        tick();
        checkOutput("q_e4_level", int'(levelUpN), 1);
        checkOutput("q_e4_restart", int'(frogRestart), 1);
        checkOutput("count_one", levelCount - startCount, 1);
        applyStimulus(1'b1, 1'b1, 3'd0);
        tick();
        checkOutput("cd_enter_busy", int'(busy), 1);
        checkOutput("cd_enter_restart", int'(frogRestart), 0);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        checkOutput("cd_length", n, 16);

        // Goal row for three edges then leaving it aborts
        startCount = levelCount;
        applyStimulus(1'b1, 1'b1, 3'd7);
        tick(); tick(); tick();
        checkOutput("abort_row_busy_mid", int'(busy), 1);
        applyStimulus(1'b1, 1'b1, 3'd6);
        tick();
        checkOutput("abort_row_busy", int'(busy), 0);
        checkOutput("abort_row_level", int'(levelUpN), 1);

        // Collision on the completing edge aborts
        applyStimulus(1'b1, 1'b1, 3'd7);
        tick(); tick(); tick();
        applyStimulus(1'b1, 1'b0, 3'd7);
        tick();
        checkOutput("abort_col_level", int'(levelUpN), 1);
        checkOutput("abort_col_busy", int'(busy), 0);

        // Game disabled on the second edge aborts
        applyStimulus(1'b1, 1'b1, 3'd7);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd7);
        tick();
        checkOutput("abort_en_busy", int'(busy), 0);
        applyStimulus(1'b0, 1'b1, 3'd0);
        tick(); tick(); tick();
        checkOutput("abort_count", levelCount - startCount, 0);

        // Frog parked on goal row for 100 cycles: exactly one pulse
        startCount = levelCount;
        lows = 0;
        prevLow = 1'b0;
        applyStimulus(1'b1, 1'b1, 3'd7);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!levelUpN) begin
                lows++;
                if (prevLow) checkOutput("back_to_back", 1, 0);
            end
            prevLow = !levelUpN;
        end
        checkOutput("park_pulses", lows, 1);
        checkOutput("park_busy", int'(busy), 1);
        applyStimulus(1'b1, 1'b1, 3'd0);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        checkOutput("park_exit_cycles", n, 1);
        applyStimulus(1'b1, 1'b1, 3'd7);
        tick(); tick(); tick(); tick();
        checkOutput("second_pulse", int'(levelUpN), 0);
        tick();
        checkOutput("count_two", levelCount - startCount, 2);

        // Asynchronous reset in the middle of a pulse
        applyStimulus(1'b1, 1'b1, 3'd0);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        checkOutput("pre_async_idle", int'(busy), 0);
        applyStimulus(1'b1, 1'b1, 3'd7);
        tick(); tick(); tick(); tick();
        checkOutput("async_pulse_low", int'(levelUpN), 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_level", int'(levelUpN), 1);
        checkOutput("async_busy", int'(busy), 0);
        tick();
        applyStimulus(1'b1, 1'b1, 3'd0);
        reset = 1'b0;
        tick();
        checkOutput("async_post_busy", int'(busy), 0);
        checkOutput("async_post_restart", int'(frogRestart), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sc_level_advance_pulser.md
Name: sc_level_advance_pulser

Overview:
- Upstream stage of the level counter in the Frogger datapath.
- Watches the frog row position and qualifies a "goal reached" event.
- Emits exactly one single-cycle active-low pulse per level completion; this pulse drives the counter's increment input directly.
- Also issues a one-cycle frog-restart request, then locks out re-triggering until the frog leaves the goal row.

Parameters:
- ROW_DATAWIDTH, 3, width of the frog row index.
- GOAL_ROW, 7, row index that counts as level complete.
- HOLD_CYCLES, 4, consecutive qualifying clock edges required before the pulse; legal range >=1.
- COOLDOWN_CYCLES, 16, minimum number of cycles spent in COOLDOWN; legal range >=1.
- CNT_DATAWIDTH, 8, width of the internal hold and cooldown counters; must hold max(HOLD_CYCLES, COOLDOWN_CYCLES).

Ports:
- SC_COUNTER_LEVELS_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_COUNTER_LEVELS_RESET_InHigh  in  1  asynchronous, active-high reset.
- frog_row_InBus  in  ROW_DATAWIDTH  current frog row index, synchronous to the clock.
- game_enable_InHigh  in  1  game running; qualification only proceeds while high.
- collision_InLow  in  1  frog collision, active low; aborts qualification.
- level_up_OutLow  out  1  one-cycle low pulse per completed level; feeds the level counter increment input.
- frog_restart_OutHigh  out  1  one-cycle high request to return the frog to the start row.
- busy_OutHigh  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, immediate on assertion, including mid-operation):
  - state=IDLE, hold_cnt=0, cd_cnt=0.
  - level_up_OutLow=1, frog_restart_OutHigh=0, busy_OutHigh=0.
- Qualify condition Q = game_enable_InHigh==1 AND collision_InLow==1 AND frog_row_InBus==GOAL_ROW.
- Outputs are Moore, decoded only from the state register, so there is no combinational path from inputs to outputs.
- IDLE:
  - If Q and HOLD_CYCLES==1, go to PULSE.
  - Else if Q, go to QUALIFY with hold_cnt=1.
  - Else stay in IDLE.
- QUALIFY:
  - If not Q, go to IDLE and set hold_cnt=0. Leaving the goal row, a collision and disabling the game all abort.
  - If Q and hold_cnt==HOLD_CYCLES-1, go to PULSE.
  - If Q otherwise, hold_cnt+1.
- PULSE:
  - level_up_OutLow=0 for exactly this one cycle.
  - Unconditionally go to RESTART; inputs are ignored.
- RESTART:
  - frog_restart_OutHigh=1 for exactly this one cycle.
  - Unconditionally go to COOLDOWN with cd_cnt=0.
- COOLDOWN:
  - cd_cnt increments and saturates at COOLDOWN_CYCLES-1.
  - Exit to IDLE only when cd_cnt==COOLDOWN_CYCLES-1 AND frog_row_InBus!=GOAL_ROW.
  - If the frog is still on GOAL_ROW, remain in COOLDOWN indefinitely; no second pulse.
- busy_OutHigh=1 in QUALIFY, PULSE, RESTART and COOLDOWN.
- Latency: with Q first sampled true at edge E0 and held, the FSM enters PULSE at edge E(HOLD_CYCLES-1). level_up_OutLow is therefore low during the cycle following that edge.
  - Default HOLD_CYCLES=4: the pulse falls in the cycle after the 4th qualifying edge.
- Guarantee: level_up_OutLow is never low on two consecutive cycles. Minimum spacing between pulses is HOLD_CYCLES+COOLDOWN_CYCLES+2 cycles.
- Simultaneous events:
  - A collision on the same edge that would complete qualification aborts; no pulse.
  - game_enable_InHigh falling during PULSE, RESTART or COOLDOWN does not cancel them.
- Unused state encodings recover to IDLE on the next edge.

Test Plan:
- Assert reset for 3 cycles with random inputs -> level_up_OutLow=1, frog_restart_OutHigh=0, busy_OutHigh=0 throughout; FSM in IDLE after release.
- Defaults; enable=1, collision_InLow=1, frog_row=7 held -> level_up_OutLow=0 for exactly 1 cycle after the 4th qualifying edge, frog_restart_OutHigh=1 on the next cycle. The attached level counter goes 0->1.
- frog_row=7 for 3 edges, then 6 -> no pulse; busy_OutHigh returns to 0 after the 4th edge; counter stays 0.
- frog_row=7 and collision_InLow=0 on the 4th edge -> no pulse. Repeat with game_enable_InHigh=0 on edge 2 -> no pulse.
- frog_row held at 7 for 100 cycles -> exactly one pulse. Set row=0 after cooldown, then row=7 for 4 edges -> second pulse; counter reads 2.
- Assert reset asynchronously mid-PULSE -> level_up_OutLow returns to 1 without waiting for a clock edge; FSM in IDLE after release.
